// File: rtl/rr_arb_32b.sv
// rr_arb_32b: 32-requester round-robin arbiter with registered one-hot grant.
// The candidate is found by a masked two-level priority search (8-bit groups,
// then one of 4 groups). It is registered (cand_q) and then re-qualified
// before the grant is issued. A grant is held until done, until the owner
// drops its request, or until MAX_HOLD cycles have elapsed. The round-robin
// pointer then moves to the requester after the owner.
// Optional feature: define ARB_LOCK_EN to add a 'lock' input. While lock is
// high in GRANT, the hold timeout is suppressed.
module rr_arb_32b #(
   parameter int N        = 32,
   parameter int IDW      = $clog2(N),
   parameter int MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic           done,
`ifdef ARB_LOCK_EN
   input  logic           lock,
`endif
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_val,
   output logic           busy
);

   localparam int GW  = 8;   // bits per search group
   localparam int NG  = 4;   // number of groups
   localparam int HCW = 8;   // hold counter width, covers MAX_HOLD up to 255

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_GRANT = 2'd2,
      ST_REL   = 2'd3
   } state_t;

   state_t         state_q;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] cand_q;
   logic [IDW-1:0] cand_d;
   logic [HCW-1:0] hold_cnt_q;
   logic [N-1:0]   gnt_q;
   logic [IDW-1:0] gnt_id_q;
   logic           gnt_val_q;
   logic           busy_q;

   logic [N-1:0]        mask;
   logic [N-1:0]        masked;
   logic [N-1:0]        pool;
   logic [NG-1:0]       grp_any;
   logic [NG-1:0][2:0]  grp_low;
   logic [1:0]          grp_sel;
   logic                hold_max;
   logic                rel_now;

   // Two-level search: lowest set bit at or above ptr, else lowest set bit overall.
   always_comb begin
      // NOTE: every signal gets a default before any conditional update, so no latch is inferred.
      mask    = {N{1'b1}} << ptr_q;
      masked  = req & mask;
      pool    = (|masked) ? masked : req;
      grp_any = '0;
      grp_low = '0;
      grp_sel = '0;
      for (int g = 0; g < NG; g++) begin
         grp_any[g] = |pool[g*GW +: GW];
         for (int b = GW - 1; b >= 0; b--) begin
            if (pool[g*GW + b]) grp_low[g] = 3'(b);
         end
      end
      for (int g = NG - 1; g >= 0; g--) begin
         if (grp_any[g]) grp_sel = 2'(g);
      end
      cand_d = {grp_sel, grp_low[grp_sel]};
   end

   // Release decision for the current owner; simultaneous causes collapse into one release.
   always_comb begin
      hold_max = (hold_cnt_q == HCW'(MAX_HOLD));
`ifdef ARB_LOCK_EN
      rel_now  = done || !req[gnt_id_q] || (hold_max && !lock);
`else
      rel_now  = done || !req[gnt_id_q] || hold_max;
`endif
   end

   // Arbitration FSM with registered grant and status outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cand_q     <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         gnt_val_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  cand_q  <= cand_d;
                  state_q <= ST_ARB;
                  busy_q  <= 1'b1;
               end
            end
            ST_ARB: begin
               if (req[cand_q]) begin
                  gnt_q      <= N'(1) << cand_q;
                  gnt_id_q   <= cand_q;
                  gnt_val_q  <= 1'b1;
                  hold_cnt_q <= HCW'(1);
                  state_q    <= ST_GRANT;
               end else if (|req) begin
                  cand_q <= cand_d;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (rel_now) begin
                  gnt_q     <= '0;
                  gnt_val_q <= 1'b0;
                  ptr_q     <= gnt_id_q + IDW'(1);
                  state_q   <= ST_REL;
               end else if (!hold_max) begin
                  hold_cnt_q <= hold_cnt_q + HCW'(1);
               end
            end
            ST_REL: begin
               if (|req) begin
                  cand_q  <= cand_d;
                  state_q <= ST_ARB;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_val = gnt_val_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_rr_arb_32b.sv
// tb_rr_arb_32b: directed scenarios with literal expectations plus a
// randomized run. A behavioural arbiter model tracks the owner, the pending
// candidate and the release bubble, and it is compared on every negedge.
module tb_rr_arb_32b;

   localparam int N        = 32;
   localparam int IDW      = 5;
   localparam int MAX_HOLD = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic           done = 1'b0;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_val;
   logic           busy;

   int n_checks = 0;
   int n_fail   = 0;
   bit live     = 1'b0;

   always #5 clk = ~clk;

   rr_arb_32b #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
`ifdef ARB_LOCK_EN
      .lock    (1'b0),
`endif
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_val (gnt_val),
      .busy    (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   int m_owner  = -1;   // index currently granted, -1 if none
   int m_cand   = -1;   // index chosen but not yet granted, -1 if none
   bit m_bubble = 1'b0; // the release cycle that follows a grant
   int m_ptr    = 0;
   int m_hold   = 0;
   int m_gid    = 0;

   // Rotational search: the first requester at or after p, wrapping around.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_owner = -1; m_cand = -1; m_bubble = 1'b0;
         m_ptr = 0; m_hold = 0; m_gid = 0;
      end else if (m_owner >= 0) begin
         if (done || !req[m_owner] || m_hold == MAX_HOLD) begin
            m_ptr    = (m_owner + 1) % N;
            m_owner  = -1;
            m_bubble = 1'b1;
         end else begin
            m_hold++;
         end
      end else if (m_cand >= 0) begin
         if (req[m_cand]) begin
            m_owner = m_cand;
            m_gid   = m_cand;
            m_hold  = 1;
            m_cand  = -1;
         end else begin
            m_cand = pick(req, m_ptr);
         end
      end else begin
         m_bubble = 1'b0;
         m_cand   = pick(req, m_ptr);
      end
   end

   // Compare the DUT against the model every cycle once reset has been applied.
   always @(negedge clk) begin
      if (live) begin
         logic [N-1:0] exp_gnt;
         exp_gnt = (m_owner >= 0) ? (N'(1) << m_gid) : '0;
         check("cmp_gnt", 64'(gnt), 64'(exp_gnt));
         check("cmp_gnt_id", 64'(gnt_id), 64'(m_gid));
         check("cmp_gnt_val", 64'(gnt_val), 64'(m_owner >= 0));
         check("cmp_busy", 64'(busy), 64'((m_owner >= 0) || (m_cand >= 0) || m_bubble));
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic wait_grant(input string name);
      int n = 0;
      while (!gnt_val && n < 100) begin
         tick();
         n++;
      end
      check(name, 64'(gnt_val), 64'd1);
   endtask

   initial begin
      int order [4] = '{0, 31, 0, 31};
      int cnt;

      // Reset held for two cycles, then ten idle cycles.
      rst = 1'b0; req = '0; done = 1'b0;
      tick(); tick();
      rst  = 1'b1;
      live = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_busy", 64'(busy), 64'd0);
         check("idle_gnt", 64'(gnt), 64'd0);
      end

      // Single request to index 4.
      req = 32'h0000_0010;
      tick();
      check("single_arb_val", 64'(gnt_val), 64'd0);
      check("single_arb_busy", 64'(busy), 64'd1);
      tick();
      check("single_val", 64'(gnt_val), 64'd1);
      check("single_id", 64'(gnt_id), 64'd4);
      check("single_gnt", 64'(gnt), 64'h10);
      done = 1'b1; req = '0;
      tick();
      done = 1'b0;
      check("single_rel_gnt", 64'(gnt), 64'd0);
      check("single_rel_id_held", 64'(gnt_id), 64'd4);
      tick();
      check("single_busy_back", 64'(busy), 64'd0);
      // The pointer now sits at 5, so 5 beats 0.
      req = 32'h0000_0021;
      tick(); tick();
      check("ptr5_id", 64'(gnt_id), 64'd5);
      done = 1'b1; req = '0;
      tick();
      done = 1'b0;
      tick();

      // Round-robin wrap between requesters 0 and 31.
      do_reset();
      req = 32'h8000_0001;
      for (int k = 0; k < 4; k++) begin
         wait_grant("wrap_wait");
         check("wrap_id", 64'(gnt_id), 64'(order[k]));
         done = 1'b1;
         if (k == 3) req = '0;
         tick();
         done = 1'b0;
         check("wrap_bubble", 64'(gnt_val), 64'd0);
      end
      tick(); tick();

      // Timeout: a held request is released after MAX_HOLD cycles and regranted.
      do_reset();
      req = 32'h0000_0100;
      wait_grant("to_wait");
      cnt = 0;
      while (gnt_val && cnt < 300) begin
         cnt++;
         tick();
      end
      check("to_high_cycles", 64'(cnt), 64'd16);
      cnt = 0;
      while (!gnt_val && cnt < 50) begin
         cnt++;
         tick();
      end
      check("to_gap_cycles", 64'(cnt), 64'd2);
      check("to_regrant_id", 64'(gnt_id), 64'd8);
      req = '0;
      tick(); tick(); tick();

      // Withdrawal: the candidate 3 drops while in ARB, so 9 is granted.
      do_reset();
      req = (N'(1) << 3) | (N'(1) << 9);
      tick();
      req = N'(1) << 9;
      tick();
      check("wd_no_grant_yet", 64'(gnt_val), 64'd0);
      check("wd_no3", 64'(gnt[3]), 64'd0);
      tick();
      check("wd_id", 64'(gnt_id), 64'd9);
      check("wd_gnt", 64'(gnt), 64'(N'(1) << 9));
      req = '0;
      tick();
      check("wd_drop_rel", 64'(gnt_val), 64'd0);
      tick(); tick();

      // Reset while requester 17 owns the grant.
      req = N'(1) << 17;
      wait_grant("mid_wait");
      check("mid_id17", 64'(gnt_id), 64'd17);
      rst = 1'b0;
      tick();
      check("mid_rst_gnt", 64'(gnt), 64'd0);
      check("mid_rst_id", 64'(gnt_id), 64'd0);
      check("mid_rst_val", 64'(gnt_val), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      req = 32'h0002_0001;
      tick(); tick();
      check("mid_first0", 64'(gnt_id), 64'd0);
      check("mid_first0_val", 64'(gnt_val), 64'd1);
      done = 1'b1; req = 32'h0002_0000;
      tick();
      done = 1'b0;
      wait_grant("mid_wait17");
      check("mid_then17", 64'(gnt_id), 64'd17);
      req = '0;
      tick(); tick(); tick();

      // Randomized traffic, done pulses and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(7) == 0) begin
            case ($urandom_range(3))
               0:       req = $urandom();
               1:       req = (N'(1) << $urandom_range(31)) | (N'(1) << $urandom_range(31));
               2:       req = '0;
               default: req = 32'h8000_0001;
            endcase
         end
         done = ($urandom_range(15) == 0);
         rst  = ($urandom_range(499) != 0);
         tick();
      end
      rst = 1'b1; done = 1'b0; req = '0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
